fetch_sequencer: RTL and testbench

Fetch-stage controller that owns the architectural PC and sequences instruction fetch for the 5-stage pipeline. It arbitrates between sequential fetch, ID-stage unconditional redirects (B/BL) and EX-stage redirects (taken CBZ/B.LT, BR). It also handles hazard-unit stalls and a req/ready instruction-memory handshake, and generates the IF/ID and ID/EX flush strobes. It sits between the hazard unit, the branch-target datapath and instruction memory.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/adder_4_pc.sv | 18 +
 rtl/sat_counter.sv | 32 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch-stage controller.
//   state_t     : fetch FSM encoding (RESET, FETCH, DRAIN)
//   INST_BYTES  : size of one instruction word in bytes
//   align_pc()  : clears the low address bits so a target is word aligned
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned INST_BYTES = 4;

  // Redirect targets are architecturally word aligned; the low bits coming
  // from the target datapath are not trusted.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/adder_4_pc.sv
// -----------------------------------------------------------------------------
// adder_4_pc
// Sequential-address adder: pc_plus4 = pc + INST_BYTES, modulo 2^64.
// Also serves as the BL link value.
// Ports:
//   pc       in  64  current fetch address
//   pc_plus4 out 64  next sequential address (wraps at 2^64)
// -----------------------------------------------------------------------------
module adder_4_pc
  import fetch_pkg::*;
(
  input  logic [63:0] pc,
  output logic [63:0] pc_plus4
);

  assign pc_plus4 = pc + 64'(INST_BYTES);

endmodule

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. Increments by one on each clock with inc high and
// holds at all-ones.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-low reset, clears count
//   inc   in  1  increment request for this cycle
//   count out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetch-stage controller. Owns the architectural PC and sequences instruction
// fetch, arbitrating between sequential fetch, ID-stage unconditional
// redirects and EX-stage redirects, honouring hazard stalls and the
// instruction-memory req/ready handshake, and producing pipeline flushes.
//
// Memory handshake: imem_req high means "the word at pc is requested".
// A request is complete in the cycle imem_ready is high; until then pc and
// imem_req are held stable. A redirect seen while a request is still
// outstanding parks its target in pend_target (DRAIN) and applies it once
// the outstanding word returns; that word is discarded.
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-low reset
//   stall        in  1      hazard freeze; IF/ID cannot accept this cycle
//   imem_ready   in  1      memory returns the word at pc this cycle
//   id_br_valid  in  1      ID-stage taken unconditional branch
//   id_br_target in  64     ID redirect target
//   ex_br_valid  in  1      EX-stage taken redirect
//   ex_br_target in  64     EX redirect target
//   pc           out 64     current fetch address
//   pc_plus4     out 64     pc + 4 (combinational, BL link value)
//   imem_req     out 1      fetch request for pc
//   if_valid     out 1      write IF/ID this cycle
//   flush_ifid   out 1      squash IF/ID this cycle
//   flush_idex   out 1      squash ID/EX this cycle
//   redirect_cnt out CNT_W  accepted redirects, saturating
//   state        out 2      FSM state, for observation
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             id_br_valid,
  input  logic [63:0]      id_br_target,
  input  logic             ex_br_valid,
  input  logic [63:0]      ex_br_target,
  output logic [63:0]      pc,
  output logic [63:0]      pc_plus4,
  output logic             imem_req,
  output logic             if_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] redirect_cnt,
  output state_t           state
);

  logic [63:0] pend_target;
  logic        in_fetch;
  logic        in_drain;
  logic        take_ex;
  logic        take_id;
  logic        redirect;
  logic [63:0] redir_target;

  adder_4_pc u_adder (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // ---------------------------------------------------------------------------
  // Redirect arbitration. EX is the older instruction and always wins.
  // An ID redirect seen in DRAIN comes from a slot that is already being
  // squashed, so it is not accepted there. Nothing is accepted in RESET.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_fetch     = (state == FETCH);
    in_drain     = (state == DRAIN);
    take_ex      = ex_br_valid && (in_fetch || in_drain);
    take_id      = id_br_valid && !ex_br_valid && in_fetch;
    redirect     = take_ex || take_id;
    redir_target = ex_br_valid ? align_pc(ex_br_target) : align_pc(id_br_target);
  end

  // Both redirect sources kill the word in IF/ID; only EX also kills the
  // instruction already decoded into ID/EX.
  assign flush_ifid = redirect;
  assign flush_idex = take_ex;

  // A returned word is only usable on the sequential path with IF/ID free.
  assign if_valid = in_fetch && imem_ready && !ex_br_valid && !id_br_valid && !stall;

  // ---------------------------------------------------------------------------
  // Fetch FSM: owns pc, pend_target and the registered imem_req.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RESET;
      pc          <= RESET_PC;
      pend_target <= '0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          imem_req <= 1'b1;
          if (redirect) begin
            if (imem_ready) begin
              // Request completes now; its wrong-path word is dropped.
              pc <= redir_target;
            end else begin
              // Request still outstanding: keep address stable until ready.
              pend_target <= redir_target;
              state       <= DRAIN;
            end
          end else if (!stall && imem_ready) begin
            pc <= pc_plus4;
          end
          // Under stall the returned word is discarded and pc is refetched.
        end

        DRAIN: begin
          imem_req <= 1'b1;
          if (imem_ready) begin
            // An EX redirect arriving with the completing ready supersedes
            // the parked target.
            pc    <= take_ex ? redir_target : pend_target;
            state <= FETCH;
          end else if (take_ex) begin
            pend_target <= redir_target;
          end
        end

        default: begin
          state    <= RESET;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Simultaneous EX and ID redirects are one accepted redirect.
  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_pkg::*;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        id_br_valid = 1'b0;
  logic [63:0] id_br_target = '0;
  logic        ex_br_valid = 1'b0;
  logic [63:0] ex_br_target = '0;

  logic [63:0] pc, pc_plus4;
  logic        imem_req, if_valid, flush_ifid, flush_idex;
  logic [31:0] redirect_cnt;
  state_t      state;

  logic [63:0] pc2, pc_plus4_2;
  logic        imem_req2, if_valid2, flush_ifid2, flush_idex2;
  logic [1:0]  redirect_cnt2;
  state_t      state2;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .id_br_valid(id_br_valid), .id_br_target(id_br_target),
    .ex_br_valid(ex_br_valid), .ex_br_target(ex_br_target),
    .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .if_valid(if_valid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect_cnt(redirect_cnt), .state(state)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation.
  fetch_sequencer #(.RESET_PC(64'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .id_br_valid(id_br_valid), .id_br_target(id_br_target),
    .ex_br_valid(ex_br_valid), .ex_br_target(ex_br_target),
    .pc(pc2), .pc_plus4(pc_plus4_2), .imem_req(imem_req2), .if_valid(if_valid2),
    .flush_ifid(flush_ifid2), .flush_idex(flush_idex2),
    .redirect_cnt(redirect_cnt2), .state(state2)
  );

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;

  function automatic logic [1:0] sat3(input int c);
    return (c > 3) ? 2'd3 : 2'(c);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (pc_plus4 !== 64'h4) begin errors++; $display("FAIL reset_pc_plus4 got=%h exp=4", pc_plus4); end
    checks++; if ({imem_req, if_valid, flush_ifid, flush_idex} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0000", {imem_req, if_valid, flush_ifid, flush_idex}); end
    checks++; if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); end
    checks++; if (state !== RESET) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, RESET); end
    checks++; if ({pc2, pc_plus4_2, imem_req2, if_valid2, flush_ifid2, flush_idex2, redirect_cnt2, state2}
                  !== {64'h0, 64'h4, 4'b0000, 2'b00, RESET}) begin
      errors++; $display("FAIL reset_dut2 pc=%h req=%b cnt=%0d state=%0d", pc2, imem_req2, redirect_cnt2, state2); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_req got=%b exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || state !== FETCH) begin
      errors++; $display("FAIL reset_to_fetch req=%b state=%0d exp req=1 state=FETCH", imem_req, state); end
  endtask

  task automatic test_sequential;
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc || pc2 !== exp_pc) begin
        errors++; $display("FAIL seq_pc[%0d] got=%h/%h exp=%h", i, pc, pc2, exp_pc); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_if_valid[%0d] got=%b exp=1", i, if_valid); end
      tick();
    end
    imem_ready = 1'b0;
    checks++; if (pc !== 64'd20) begin errors++; $display("FAIL seq_pc_end got=%h exp=14", pc); end
    checks++; if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL seq_cnt got=%0d exp=0", redirect_cnt); end
  endtask

  task automatic test_both_redirect;
    ex_br_valid = 1'b1; ex_br_target = 64'h100;
    id_br_valid = 1'b1; id_br_target = 64'h200;
    imem_ready = 1'b1;
    exp_cnt++;
    exp_q.push_back(64'h100);
    @(negedge clk);
    checks++; if ({flush_ifid, flush_idex, if_valid} !== 3'b110) begin
      errors++; $display("FAIL both_flags got=%b exp=110", {flush_ifid, flush_idex, if_valid}); end
    tick();
    ex_br_valid = 1'b0; id_br_valid = 1'b0; imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL both_pc got=%h exp=%h", pc, exp_pc); end
    checks++; if (redirect_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL both_cnt got=%0d exp=%0d", redirect_cnt, exp_cnt); end
    checks++; if (redirect_cnt2 !== sat3(exp_cnt)) begin errors++; $display("FAIL both_cnt2 got=%0d exp=%0d", redirect_cnt2, sat3(exp_cnt)); end
  endtask

  task automatic test_drain_id;
    id_br_valid = 1'b1; id_br_target = 64'h40;
    imem_ready = 1'b0;
    exp_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (pc !== 64'h100 || imem_req !== 1'b1) begin
        errors++; $display("FAIL drain_id_hold[%0d] pc=%h req=%b exp pc=100 req=1", c, pc, imem_req); end
      checks++; if (state !== ((c == 0) ? FETCH : DRAIN)) begin
        errors++; $display("FAIL drain_id_state[%0d] got=%0d", c, state); end
      checks++; if ({flush_ifid, flush_idex} !== ((c == 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL drain_id_flush[%0d] got=%b", c, {flush_ifid, flush_idex}); end
      tick();
    end
    id_br_valid = 1'b0; imem_ready = 1'b1;
    exp_q.push_back(64'h40);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_id_if_valid got=%b exp=0", if_valid); end
    tick();
    imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || state !== FETCH) begin
      errors++; $display("FAIL drain_id_pc got=%h state=%0d exp=%h FETCH", pc, state, exp_pc); end
    checks++; if (redirect_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL drain_id_cnt got=%0d exp=%0d", redirect_cnt, exp_cnt); end
  endtask

  task automatic test_drain_ex;
    // ID redirect parks, then an unaligned EX target overrides it.
    id_br_valid = 1'b1; id_br_target = 64'h40; imem_ready = 1'b0;
    exp_cnt++;
    tick();
    id_br_valid = 1'b0;
    checks++; if (state !== DRAIN) begin errors++; $display("FAIL drain_ex_state got=%0d exp=DRAIN", state); end
    ex_br_valid = 1'b1; ex_br_target = 64'h83;
    exp_cnt++;
    @(negedge clk);
    checks++; if ({flush_ifid, flush_idex} !== 2'b11) begin
      errors++; $display("FAIL drain_ex_flush got=%b exp=11", {flush_ifid, flush_idex}); end
    tick();
    ex_br_valid = 1'b0; imem_ready = 1'b1;
    exp_q.push_back(64'h80);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_ex_if_valid got=%b exp=0", if_valid); end
    tick();
    imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL drain_ex_pc got=%h exp=%h", pc, exp_pc); end
    checks++; if (redirect_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL drain_ex_cnt got=%0d exp=%0d", redirect_cnt, exp_cnt); end
    // EX redirect arriving with the completing ready wins over the parked one.
    id_br_valid = 1'b1; id_br_target = 64'h500;
    exp_cnt++;
    tick();
    id_br_valid = 1'b0;
    ex_br_valid = 1'b1; ex_br_target = 64'h600; imem_ready = 1'b1;
    exp_cnt++;
    exp_q.push_back(64'h600);
    tick();
    ex_br_valid = 1'b0; imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || state !== FETCH) begin
      errors++; $display("FAIL drain_ex_same_cycle got=%h state=%0d exp=%h", pc, state, exp_pc); end
  endtask

  task automatic test_stall;
    ex_br_valid = 1'b1; ex_br_target = 64'h20; imem_ready = 1'b1;
    exp_cnt++;
    tick();
    ex_br_valid = 1'b0;
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || pc !== 64'h20) begin
        errors++; $display("FAIL stall_hold[%0d] if_valid=%b pc=%h exp 0 20", c, if_valid, pc); end
      tick();
    end
    stall = 1'b0;
    exp_q.push_back(64'h24);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got=%b exp=1", if_valid); end
    tick();
    imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_release_pc got=%h exp=%h", pc, exp_pc); end
  endtask

  task automatic test_wrap;
    ex_br_valid = 1'b1; ex_br_target = 64'hFFFF_FFFF_FFFF_FFFC; imem_ready = 1'b1;
    exp_cnt++;
    tick();
    ex_br_valid = 1'b0;
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus4 !== 64'h0) begin
      errors++; $display("FAIL wrap_top pc=%h pc_plus4=%h", pc, pc_plus4); end
    exp_q.push_back(64'h0);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", if_valid); end
    tick();
    imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, exp_pc); end
    checks++; if (redirect_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL wrap_cnt got=%0d exp=%0d", redirect_cnt, exp_cnt); end
    checks++; if (redirect_cnt2 !== sat3(exp_cnt)) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=%0d", redirect_cnt2, sat3(exp_cnt)); end
  endtask

  task automatic test_reset_mid_drain;
    id_br_valid = 1'b1; id_br_target = 64'h300; imem_ready = 1'b0;
    tick();
    id_br_valid = 1'b0;
    checks++; if (state !== DRAIN) begin errors++; $display("FAIL rmd_state got=%0d exp=DRAIN", state); end
    #2 rst = 1'b0;
    #1;
    exp_cnt = 0;
    checks++; if (pc !== 64'h0 || state !== RESET) begin
      errors++; $display("FAIL rmd_pc pc=%h state=%0d exp 0 RESET", pc, state); end
    checks++; if ({imem_req, if_valid, flush_ifid, flush_idex} !== 4'b0) begin
      errors++; $display("FAIL rmd_outputs got=%b exp=0000", {imem_req, if_valid, flush_ifid, flush_idex}); end
    checks++; if (redirect_cnt !== 32'd0 || redirect_cnt2 !== 2'd0) begin
      errors++; $display("FAIL rmd_cnt got=%0d/%0d exp=0", redirect_cnt, redirect_cnt2); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    imem_ready = 1'b1;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    @(negedge clk);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || if_valid !== 1'b1) begin
      errors++; $display("FAIL rmd_restart pc=%h if_valid=%b exp %h 1", pc, if_valid, exp_pc); end
    tick();
    imem_ready = 1'b0;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rmd_next_pc got=%h exp=%h", pc, exp_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_both_redirect();
    test_drain_id();
    test_drain_ex();
    test_stall();
    test_wrap();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
